// File: rtl/miss_repair_unit.sv
// miss_repair_unit: single-outstanding miss repair engine between the MSHR and memory.
// Define MISS_REPAIR_TIMEOUT_EN to abort responses that never arrive after TIMEOUT_CYCLES.
package core_pkg;
    parameter int ROB_ENTRIES = 32;
endpackage

module miss_repair_unit
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           repair_req_i,
    input  logic [31:0]                    repair_req_addr_i,
    input  logic [31:0]                    repair_req_data_i,
    input  logic [$clog2(ROB_ENTRIES)-1:0] repair_req_rob_idx_i,
    input  logic                           repair_is_store_i,
    output logic                           repair_ack_o,
    output logic                           repair_complete_o,
    output logic                           mem_req_o,
    output logic                           mem_we_o,
    output logic [31:0]                    mem_addr_o,
    output logic [31:0]                    mem_wdata_o,
    input  logic                           mem_ready_i,
    input  logic                           mem_resp_vld_i,
    input  logic [31:0]                    mem_rdata_i,
    output logic                           fill_en_o,
    output logic [31:0]                    fill_addr_o,
    output logic [31:0]                    fill_data_o,
    output logic                           ld_wb_vld_o,
    output logic [31:0]                    ld_wb_data_o,
    output logic [$clog2(ROB_ENTRIES)-1:0] ld_wb_rob_idx_o,
    output logic                           err_o
);
    localparam int RW = $clog2(ROB_ENTRIES);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESPOND} state_t;
    state_t state, state_nxt;
    logic [31:0] addr_q, data_q, rdata_q;
    logic [RW-1:0] rob_q;
    logic store_q, squash_q, drop_q, err_q, timeout, ack;
    assign ack = !rst_i && state == IDLE && repair_req_i && !flush_i;
`ifdef MISS_REPAIR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    assign timeout = state == WAIT_RESP && !mem_resp_vld_i && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    // Held at zero outside WAIT_RESP, so every entry starts a fresh count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= state == WAIT_RESP ? cnt_q + 1'b1 : '0;
            err_q <= timeout ? 1'b1 : ack ? 1'b0 : err_q;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_q   = 1'b0;
`endif
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = ack ? ISSUE : IDLE;
            ISSUE:     state_nxt = mem_ready_i ? WAIT_RESP : flush_i ? RESPOND : ISSUE;
            WAIT_RESP: state_nxt = (mem_resp_vld_i || timeout) ? RESPOND : WAIT_RESP;
            default:   state_nxt = IDLE;
        endcase
    end
    // A flush that beats acceptance drops the request; later flushes only squash the writeback.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q   <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            rob_q    <= '0;
            store_q  <= 1'b0;
            squash_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            if (ack) begin
                addr_q   <= repair_req_addr_i;
                data_q   <= repair_req_data_i;
                rob_q    <= repair_req_rob_idx_i;
                store_q  <= repair_is_store_i;
                squash_q <= 1'b0;
                drop_q   <= 1'b0;
            end
            if (state == ISSUE && mem_ready_i && flush_i) squash_q <= 1'b1;
            if (state == ISSUE && !mem_ready_i && flush_i) drop_q <= 1'b1;
            if (state == WAIT_RESP && flush_i) squash_q <= 1'b1;
            if (state == WAIT_RESP && mem_resp_vld_i) rdata_q <= mem_rdata_i;
        end
    end
    always_comb begin
        repair_ack_o      = ack;
        mem_req_o         = !rst_i && state == ISSUE;
        mem_we_o          = mem_req_o && store_q;
        mem_addr_o        = mem_req_o ? addr_q : '0;
        mem_wdata_o       = mem_req_o ? data_q : '0;
        repair_complete_o = !rst_i && state == RESPOND;
        fill_en_o         = repair_complete_o && !drop_q && !err_q;
        fill_addr_o       = fill_en_o ? addr_q : '0;
        fill_data_o       = !fill_en_o ? '0 : store_q ? data_q : rdata_q;
        ld_wb_vld_o       = fill_en_o && !store_q && !squash_q;
        ld_wb_data_o      = ld_wb_vld_o ? rdata_q : '0;
        ld_wb_rob_idx_o   = ld_wb_vld_o ? rob_q : '0;
        err_o             = repair_complete_o && err_q;
    end
endmodule

// File: tb/tb_miss_repair_unit.sv
// tb_miss_repair_unit: randomized self-checking bench; expected behaviour comes from a cycle-level transaction model.
module tb_miss_repair_unit;
    localparam int RW = $clog2(core_pkg::ROB_ENTRIES);
    logic clk_i = 1'b0, rst_i = 1'b1, flush_i = 1'b0;
    logic repair_req_i = 1'b0, repair_is_store_i = 1'b0;
    logic [31:0] repair_req_addr_i = '0, repair_req_data_i = '0;
    logic [RW-1:0] repair_req_rob_idx_i = '0;
    logic repair_ack_o, repair_complete_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, fill_addr_o, fill_data_o, ld_wb_data_o;
    logic mem_ready_i = 1'b0, mem_resp_vld_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic fill_en_o, ld_wb_vld_o, err_o;
    logic [RW-1:0] ld_wb_rob_idx_o;
    int tests = 0, fails = 0;

    miss_repair_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .repair_req_i(repair_req_i), .repair_req_addr_i(repair_req_addr_i),
        .repair_req_data_i(repair_req_data_i), .repair_req_rob_idx_i(repair_req_rob_idx_i),
        .repair_is_store_i(repair_is_store_i), .repair_ack_o(repair_ack_o),
        .repair_complete_o(repair_complete_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
        .mem_resp_vld_i(mem_resp_vld_i), .mem_rdata_i(mem_rdata_i), .fill_en_o(fill_en_o),
        .fill_addr_o(fill_addr_o), .fill_data_o(fill_data_o), .ld_wb_vld_o(ld_wb_vld_o),
        .ld_wb_data_o(ld_wb_data_o), .ld_wb_rob_idx_o(ld_wb_rob_idx_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    wire [3*32+32+32+RW+7-1:0] all_out = {repair_ack_o, repair_complete_o, mem_req_o, mem_we_o,
        mem_addr_o, mem_wdata_o, fill_en_o, fill_addr_o, fill_data_o, ld_wb_vld_o, ld_wb_data_o,
        ld_wb_rob_idx_o, err_o};

    // fm: 0 none, 1 flush in ISSUE before acceptance, 2 flush in WAIT_RESP, 3 flush with acceptance
    task automatic run_txn(input logic st, input logic [31:0] a, input logic [31:0] d,
                           input logic [RW-1:0] r, input int rdly, input int sdly, input int fm);
        logic [31:0] rd = $urandom;
        logic exp_fill = (fm != 1);
        logic exp_wb = !st && fm == 0;
        repair_req_i = 1'b1; repair_is_store_i = st; repair_req_addr_i = a;
        repair_req_data_i = d; repair_req_rob_idx_i = r; flush_i = 1'b0;
        mem_ready_i = 1'b0; mem_resp_vld_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if ({repair_ack_o, mem_req_o, repair_complete_o} !== 3'b100) begin
            fails++; $display("FAIL txn_ack got=%b exp=100", {repair_ack_o, mem_req_o, repair_complete_o});
        end
        @(posedge clk_i); #1;
        for (int i = 0; i <= rdly; i++) begin
            repair_req_i = $urandom; repair_req_addr_i = $urandom; repair_req_data_i = $urandom;
            repair_is_store_i = $urandom;
            mem_ready_i = (i == rdly) && fm != 1;
            flush_i = (i == rdly) && (fm == 1 || fm == 3);
            mem_resp_vld_i = $urandom; mem_rdata_i = $urandom;
            @(negedge clk_i);
            tests++;
            if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, repair_ack_o, repair_complete_o} !==
                {1'b1, st, a, d, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL issue[%0d] got req=%b we=%b addr=%h wd=%h ack=%b cmp=%b exp req=1 we=%b addr=%h wd=%h ack=0 cmp=0",
                         i, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, repair_ack_o, repair_complete_o, st, a, d);
            end
            @(posedge clk_i); #1;
        end
        if (fm != 1) begin
            for (int j = 0; j <= sdly; j++) begin
                mem_resp_vld_i = (j == sdly); mem_rdata_i = (j == sdly) ? rd : $urandom;
                flush_i = (fm == 2 && j == 0); mem_ready_i = $urandom;
                @(negedge clk_i);
                tests++;
                if ({mem_req_o, repair_ack_o, repair_complete_o, err_o} !== 4'b0) begin
                    fails++; $display("FAIL wait[%0d] got req/ack/cmp/err=%b exp=0000", j,
                                      {mem_req_o, repair_ack_o, repair_complete_o, err_o});
                end
                @(posedge clk_i); #1;
            end
        end
        repair_req_i = 1'b1; flush_i = 1'b0; mem_resp_vld_i = 1'b0; mem_ready_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if ({repair_complete_o, repair_ack_o, mem_req_o, err_o, fill_en_o, ld_wb_vld_o} !==
            {4'b1000, exp_fill, exp_wb} ||
            (exp_fill && {fill_addr_o, fill_data_o} !== {a, st ? d : rd}) ||
            (exp_wb && {ld_wb_data_o, ld_wb_rob_idx_o} !== {rd, r})) begin
            fails++;
            $display("FAIL respond got cmp=%b ack=%b req=%b err=%b fill=%b wb=%b faddr=%h fdata=%h wbd=%h rob=%0d exp 1 0 0 0 %b %b %h %h %h %0d",
                     repair_complete_o, repair_ack_o, mem_req_o, err_o, fill_en_o, ld_wb_vld_o, fill_addr_o,
                     fill_data_o, ld_wb_data_o, ld_wb_rob_idx_o, exp_fill, exp_wb, a, st ? d : rd, rd, r);
        end
        @(posedge clk_i); #1;
        repair_req_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if ({repair_complete_o, fill_en_o, ld_wb_vld_o} !== 3'b0) begin
            fails++; $display("FAIL after_respond got=%b exp=000", {repair_complete_o, fill_en_o, ld_wb_vld_o});
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; repair_req_i = 1'b1; mem_resp_vld_i = 1'b1; mem_ready_i = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            tests++;
            if (all_out !== '0) begin fails++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
            @(posedge clk_i); #1;
        end
        rst_i = 1'b0; repair_req_i = 1'b0; mem_resp_vld_i = 1'b0; mem_ready_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if (all_out !== '0) begin fails++; $display("FAIL post_reset got=%h exp=0", all_out); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_load();
        run_txn(1'b0, 32'h1000, 32'h0, RW'(5), 0, 0, 0);
    endtask

    task automatic test_store();
        run_txn(1'b1, 32'h2004, 32'h12345678, RW'(3), 0, 1, 0);
    endtask

    task automatic test_backpressure();
        run_txn(1'b0, 32'h3008, 32'h0, RW'(7), 4, 2, 0);
    endtask

    task automatic test_flush();
        run_txn(1'b0, 32'h400C, 32'h0, RW'(9), 1, 2, 2);
        run_txn(1'b0, 32'h5010, 32'h0, RW'(2), 2, 0, 1);
        run_txn(1'b0, 32'h6014, 32'h0, RW'(4), 0, 1, 3);
        run_txn(1'b1, 32'h7018, 32'hCAFEF00D, RW'(1), 0, 0, 1);
    endtask

    task automatic test_reset_mid();
        repair_req_i = 1'b1; repair_req_addr_i = 32'h8000; repair_is_store_i = 1'b0;
        @(posedge clk_i); #1;
        repair_req_i = 1'b0; mem_ready_i = 1'b1;
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1; flush_i = 1'b1; mem_resp_vld_i = 1'b1;
        @(negedge clk_i);
        tests++;
        if (all_out !== '0) begin fails++; $display("FAIL reset_mid got=%h exp=0", all_out); end
        @(posedge clk_i); #1;
        rst_i = 1'b0; flush_i = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            tests++;
            if (all_out !== '0) begin fails++; $display("FAIL reset_mid_after got=%h exp=0", all_out); end
            @(posedge clk_i); #1;
        end
        mem_resp_vld_i = 1'b0;
        run_txn(1'b0, 32'h8004, 32'h0, RW'(6), 0, 0, 0);
    endtask

`ifdef MISS_REPAIR_TIMEOUT_EN
    task automatic test_timeout();
        repair_req_i = 1'b1; repair_req_addr_i = 32'h9000; repair_is_store_i = 1'b0;
        @(posedge clk_i); #1;
        repair_req_i = 1'b0; mem_ready_i = 1'b1;
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            tests++;
            if ({repair_complete_o, err_o} !== 2'b00) begin
                fails++; $display("FAIL timeout_wait[%0d] got=%b exp=00", i, {repair_complete_o, err_o});
            end
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        tests++;
        if ({repair_complete_o, err_o, fill_en_o, ld_wb_vld_o} !== 4'b1100) begin
            fails++; $display("FAIL timeout_abort got=%b exp=1100", {repair_complete_o, err_o, fill_en_o, ld_wb_vld_o});
        end
        @(posedge clk_i); #1;
        run_txn(1'b0, 32'h9004, 32'h0, RW'(8), 0, 0, 0);
    endtask
`else
    task automatic test_timeout();
        repair_req_i = 1'b1; repair_req_addr_i = 32'h9000; repair_is_store_i = 1'b1;
        repair_req_data_i = 32'h0BADF00D;
        @(posedge clk_i); #1;
        repair_req_i = 1'b0; mem_ready_i = 1'b1;
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            tests++;
            if ({repair_complete_o, err_o} !== 2'b00) begin
                fails++; $display("FAIL no_timeout_wait[%0d] got=%b exp=00", i, {repair_complete_o, err_o});
            end
            @(posedge clk_i); #1;
        end
        mem_resp_vld_i = 1'b1;
        @(posedge clk_i); #1;
        mem_resp_vld_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if ({repair_complete_o, err_o, fill_en_o, fill_data_o} !== {3'b101, 32'h0BADF00D}) begin
            fails++; $display("FAIL late_resp got cmp=%b err=%b fill=%b fd=%h exp 1 0 1 0badf00d",
                              repair_complete_o, err_o, fill_en_o, fill_data_o);
        end
        @(posedge clk_i); #1;
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 60; k++)
            run_txn(1'($urandom), $urandom, $urandom, RW'($urandom), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
    endtask

    initial begin
        @(posedge clk_i); #1;
        test_reset();
        test_load();
        test_store();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/miss_repair_unit.md
MISS_REPAIR_UNIT -- requirements
Module: miss_repair_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning WAIT_RESP cycles before abort (used only with MISS_REPAIR_TIMEOUT_EN); ROB_ENTRIES SHALL come from CORE_PKG.
REQ-002 SHALL use one clock and a synchronous, active-high reset:
 clk_i  in  1  clock, all state updates on posedge
 rst_i  in  1  synchronous active-high reset
REQ-003 SHALL have these request-side ports:
 flush_i  in  1  pipeline flush, squashes in-flight repair
 repair_req_i  in  1  MSHR repair request valid
 repair_req_addr_i  in  32  miss address
 repair_req_data_i  in  32  store data, don't-care for loads
 repair_req_rob_idx_i  in  $clog2(ROB_ENTRIES)  ROB index
 repair_is_store_i  in  1  1=store, 0=load
 repair_ack_o  out  1  request accepted this cycle
 repair_complete_o  out  1  one-cycle pulse, repair finished
REQ-004 SHALL have these memory-side ports:
 mem_req_o  out  1  memory request valid
 mem_we_o  out  1  write enable
 mem_addr_o  out  32  request address
 mem_wdata_o  out  32  write data
 mem_ready_i  in  1  memory accepts request
 mem_resp_vld_i  in  1  response/write-ack valid
 mem_rdata_i  in  32  read data
REQ-005 SHALL have these cache-fill and writeback ports:
 fill_en_o  out  1  cache fill strobe
 fill_addr_o  out  32  fill address
 fill_data_o  out  32  fill data
 ld_wb_vld_o  out  1  load result valid
 ld_wb_data_o  out  32  load result
 ld_wb_rob_idx_o  out  $clog2(ROB_ENTRIES)  load ROB index
 err_o  out  1  timeout abort, pulses with repair_complete_o

Function
REQ-006 SHALL implement the FSM IDLE -> ISSUE -> WAIT_RESP -> RESPOND -> IDLE.
REQ-007 SHALL drive repair_ack_o = (state==IDLE) && repair_req_i && !flush_i, combinationally, so a request held by the MSHR is acked the same cycle.
REQ-008 SHALL, on ack, latch addr, data, rob_idx and is_store, clear the squash flag, and enter ISSUE.
REQ-009 SHALL, in ISSUE, hold mem_req_o=1 with mem_addr_o=latched addr, mem_we_o=latched is_store and mem_wdata_o=latched data until mem_ready_i=1, then enter WAIT_RESP.
REQ-010 SHALL hold mem_req_o=0 in every state except ISSUE.
REQ-011 SHALL ignore mem_resp_vld_i outside WAIT_RESP, and SHALL treat a response in the same cycle as acceptance as belonging to no request.
REQ-012 SHALL, in WAIT_RESP on mem_resp_vld_i, capture mem_rdata_i for loads and enter RESPOND.
REQ-013 SHALL, in RESPOND, pulse repair_complete_o=1 and fill_en_o=1 for exactly one cycle, then enter IDLE; fill_addr_o = latched addr; fill_data_o = captured rdata for loads, latched data for stores.
REQ-014 SHALL, in RESPOND, pulse ld_wb_vld_o=1 with ld_wb_data_o=captured rdata and ld_wb_rob_idx_o=latched rob_idx only for an unsquashed load.
REQ-015 SHALL handle flush_i by state:
 - flush_i in ISSUE before acceptance: drop the memory request, go to RESPOND with fill_en_o=0 and ld_wb_vld_o=0, still pulse repair_complete_o.
 - flush_i in ISSUE with mem_ready_i the same cycle, or in WAIT_RESP: set the squash flag and let the transaction finish; fill still performed, ld_wb_vld_o suppressed.
REQ-016 SHALL ack no new request in RESPOND; the earliest new ack is the cycle after RESPOND.
REQ-017 SHALL give minimum latency ack -> repair_complete_o of 3 cycles (mem_ready_i in the first ISSUE cycle, response in the first WAIT_RESP cycle).
REQ-018 SHALL hold all output pulses at 0 outside RESPOND; data outputs are don't-care when their strobes are low.

Reset
REQ-019 SHALL, on rst_i, enter IDLE and clear latched fields, squash flag and timeout counter; all outputs SHALL be 0 in the reset cycle and after it.
REQ-020 SHALL, on rst_i mid-operation, abandon the transaction without pulsing repair_complete_o; rst_i SHALL take priority over flush_i.

Configuration
REQ-021 SHALL, with MISS_REPAIR_TIMEOUT_EN defined, count WAIT_RESP cycles; when the count reaches TIMEOUT_CYCLES with no response, enter RESPOND with err_o=1, fill_en_o=0 and ld_wb_vld_o=0.
REQ-022 SHALL reset the timeout counter on every entry to WAIT_RESP.
REQ-023 SHALL, without MISS_REPAIR_TIMEOUT_EN, tie err_o to 0, include no counter, and wait indefinitely in WAIT_RESP.

Verification
REQ-024 Load: req addr=0x1000, rob=5; mem_ready_i next cycle; response rdata=0xDEADBEEF one cycle later -> ack same cycle, complete 3 cycles after ack, ld_wb_data_o=0xDEADBEEF, rob=5, fill_data_o=0xDEADBEEF.
REQ-025 Store: addr=0x2004, data=0x12345678 -> mem_we_o=1, mem_wdata_o=0x12345678, fill_data_o=0x12345678, ld_wb_vld_o=0.
REQ-026 Backpressure: mem_ready_i low for 4 cycles -> mem_req_o and address stable for 5 cycles, repair_complete_o pulses exactly once.
REQ-027 Flush in WAIT_RESP for a load -> fill_en_o=1, ld_wb_vld_o=0, repair_complete_o=1; flush in ISSUE -> no memory acceptance, complete only.
REQ-028 With MISS_REPAIR_TIMEOUT_EN and TIMEOUT_CYCLES=8, no response -> err_o and repair_complete_o pulse after 8 WAIT_RESP cycles; next request acked.
REQ-029 rst_i asserted in WAIT_RESP -> IDLE next cycle, no repair_complete_o, next request acked normally.
